quantized_conv_relu2d: RTL and testbench
========================================

Name: quantized_conv_relu2d

Overview:
- Quantized 2-D convolution with fused ReLU for the CNN accelerator layer chain.
- Holds its own input, weight and bias buffers, each loaded through simple write ports.
- On `start`, computes every output pixel of every output channel into an internal output buffer, pulses `done`, then streams the results out with a valid strobe.
- Stride 1, no internal padding; any padding is already present in the loaded input.

Parameters:
- INPUT_CHANNELS, 1, number of input feature maps (IC).
- OUTPUT_CHANNELS, 32, number of output feature maps (OC).
- KERNEL_SIZE, 3, square kernel size K.
- INPUT_WIDTH, 30, input width W, padding included.
- INPUT_HEIGHT, 30, input height H, padding included.
- SCALE, 32'd16177215, requantization multiplier, unsigned Q6.26 (real scale = SCALE/2^26).
- ZERO_POINT, 8'd0, output zero point, unsigned.

Ports:
- clk, in, 1, single clock, rising edge.
- rstn, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle start pulse; honoured only in IDLE.
- done, out, 1, one-cycle pulse when computation is complete.
- input_data_in, in, 8, unsigned activation write data.
- input_data_we, in, 1, activation write enable.
- input_data_addr, in, clog2(IC*H*W), activation address = c*H*W + r*W + col.
- weight_data_in, in, 8, signed int8 weight write data.
- weight_data_we, in, 1, weight write enable.
- weight_data_addr, in, clog2(OC*IC*K*K), weight address = ((oc*IC+ic)*K+kr)*K+kc.
- bias_data_in, in, 32, signed int32 bias write data.
- bias_data_we, in, 1, bias write enable.
- bias_data_addr, in, clog2(OC), bias address = oc.
- conv_result, out, 8, unsigned quantized output.
- conv_valid, out, 1, conv_result is valid this cycle.

Behaviour:
- Geometry: OH = H-K+1, OW = W-K+1. Default is 32x28x28 = 25088 outputs.
- Loading: writes are accepted only in IDLE, one per cycle on a rising edge while *_we=1. Writes in any other state are ignored. Buffers are RAM and are not cleared by reset.
- FSM states and transitions:
  - IDLE -> COMPUTE on start=1.
  - COMPUTE -> DONE after the last output is written to the output buffer.
  - DONE: done=1 for exactly one cycle -> WAIT (one cycle) -> STREAM.
  - STREAM -> IDLE after the last output.
  - start is ignored outside IDLE.
- Compute, per (oc, orow, ocol):
  - acc = bias[oc] + sum over ic,kr,kc of in[ic][orow+kr][ocol+kc] * w[oc][ic][kr][kc].
  - Activations are treated as unsigned 0..255; weights as signed -128..127. Products are 17-bit signed. acc is 32-bit signed with wrap (never overflows for legal sizes).
  - One MAC per cycle minimum throughput; exact compute latency is not fixed.
- Requantize:
  - p = acc * SCALE, 64-bit signed.
  - q = p >>> 26 (arithmetic), with rounding per Optional Feature.
  - y = q + ZERO_POINT.
  - ReLU/saturate: y < ZERO_POINT -> ZERO_POINT; y > 255 -> 255; otherwise y.
- Stream:
  - Order is oc outermost, then orow, then ocol.
  - If done is registered high at edge N, the first conv_valid is registered high at edge N+2.
  - Then exactly OC*OH*OW consecutive cycles with conv_valid=1 and conv_result = buffered value. No gaps, no backpressure.
  - conv_valid=0 afterwards.
- Reset values: done=0, conv_valid=0, conv_result=0, FSM=IDLE.
- Reset asserted mid-compute or mid-stream aborts immediately to IDLE. A later start recomputes from scratch using the retained buffers.
- Simultaneous start and a *_we in IDLE: the write is performed and computation begins next cycle, using the written value.

Optional Feature:
- Macro QCONV_ROUND_NEAREST_EN.
- When defined: q = (p + 2^25) >>> 26, i.e. round half toward +inf.
- When undefined: q = p >>> 26, i.e. floor.
- The default build defines it.

Test Plan:
- All inputs 1, all weights 1, bias 0, SCALE=2^26, ZP=0 -> all 25088 outputs = 9. done pulses once; first conv_valid 2 cycles after done; exactly 25088 valid cycles.
- Weights -1, inputs 1, bias 0 -> acc = -9 -> every output = ZERO_POINT (0). With ZP=10 every output = 10.
- Inputs 255, weights 127, bias 0, SCALE=2^26 -> acc = 291465 -> output saturates to 255.
- Inputs 1, weights 1, bias -5 -> 4. Bias +1000 with SCALE=16177215 -> acc 1009 -> 243 (rounded; 243 floor as well). Bench uses a per-channel distinct bias to check oc ordering.
- Rounding: acc = 3 via bias 3 and weights 0, SCALE=2^25 -> 2 with QCONV_ROUND_NEAREST_EN, 1 without.
- Reset pulse mid-COMPUTE -> done/conv_valid stay 0. A new start then produces the correct full stream. start during STREAM is ignored; output count stays 25088.

Source files
------------

// File: rtl/quantized_conv_relu2d.sv
// quantized_conv_relu2d
//   Quantized 2-D convolution (stride 1, no internal padding) with fused
//   requantization and ReLU/saturation. Holds its own activation, weight and
//   bias RAMs (loaded only while idle), computes every output pixel of every
//   output channel into an internal output RAM at one MAC per cycle, pulses
//   done, waits one cycle, then streams the results (oc, orow, ocol order)
//   with conv_valid high for OC*OH*OW consecutive cycles.
//
//   Optional macro QCONV_ROUND_NEAREST_EN: when defined, requantization rounds
//   half toward +inf ((p + 2^25) >>> 26); otherwise it floors (p >>> 26).
//
// Ports
//   clk, rstn              clock (rising edge), async active-low reset
//   start                  one-cycle start pulse, honoured only in IDLE
//   done                   one-cycle pulse when the output RAM is complete
//   input_data_*           unsigned 8-bit activation write port, addr c*H*W+r*W+col
//   weight_data_*          signed 8-bit weight write port, addr ((oc*IC+ic)*K+kr)*K+kc
//   bias_data_*            signed 32-bit bias write port, addr oc
//   conv_result            unsigned 8-bit quantized output
//   conv_valid             conv_result is valid this cycle
module quantized_conv_relu2d #(
  parameter int          INPUT_CHANNELS  = 1,
  parameter int          OUTPUT_CHANNELS = 32,
  parameter int          KERNEL_SIZE     = 3,
  parameter int          INPUT_WIDTH     = 30,
  parameter int          INPUT_HEIGHT    = 30,
  parameter logic [31:0] SCALE           = 32'd16177215,
  parameter logic [7:0]  ZERO_POINT      = 8'd0,
  localparam int IA_W = (INPUT_CHANNELS*INPUT_HEIGHT*INPUT_WIDTH > 1) ?
                        $clog2(INPUT_CHANNELS*INPUT_HEIGHT*INPUT_WIDTH) : 1,
  localparam int WA_W = (OUTPUT_CHANNELS*INPUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE > 1) ?
                        $clog2(OUTPUT_CHANNELS*INPUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE) : 1,
  localparam int BA_W = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  output logic               done,
  input  logic [7:0]         input_data_in,
  input  logic               input_data_we,
  input  logic [IA_W-1:0]    input_data_addr,
  input  logic [7:0]         weight_data_in,
  input  logic               weight_data_we,
  input  logic [WA_W-1:0]    weight_data_addr,
  input  logic [31:0]        bias_data_in,
  input  logic               bias_data_we,
  input  logic [BA_W-1:0]    bias_data_addr,
  output logic [7:0]         conv_result,
  output logic               conv_valid
);

  localparam int IC    = INPUT_CHANNELS;
  localparam int OC    = OUTPUT_CHANNELS;
  localparam int K     = KERNEL_SIZE;
  localparam int H     = INPUT_HEIGHT;
  localparam int W     = INPUT_WIDTH;
  localparam int OH    = H - K + 1;
  localparam int OW    = W - K + 1;
  localparam int NPIX  = OH * OW;
  localparam int TOTAL = OC * NPIX;
  localparam int IN_D  = IC * H * W;
  localparam int WT_D  = OC * IC * K * K;

  localparam int ICW  = (IC > 1) ? $clog2(IC) : 1;
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int OHW  = (OH > 1) ? $clog2(OH) : 1;
  localparam int OWW  = (OW > 1) ? $clog2(OW) : 1;
  localparam int OA_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int SW   = $clog2(TOTAL + 1);

  localparam logic [ICW-1:0]  IC_LAST = ICW'(IC - 1);
  localparam logic [BA_W-1:0] OC_LAST = BA_W'(OC - 1);
  localparam logic [KW-1:0]   K_LAST  = KW'(K - 1);
  localparam logic [OHW-1:0]  OH_LAST = OHW'(OH - 1);
  localparam logic [OWW-1:0]  OW_LAST = OWW'(OW - 1);
  localparam logic [SW-1:0]   S_END   = SW'(TOTAL);

  typedef enum logic [2:0] {
    S_IDLE, S_COMPUTE, S_DONE, S_WAIT, S_STREAM
  } state_t;

  state_t r_state, w_state_nxt;

  // Buffers are plain RAM: no reset, contents survive an aborted run.
  logic [7:0]        r_in_mem  [IN_D];
  logic signed [7:0] r_w_mem   [WT_D];
  logic [31:0]       r_b_mem   [OC];
  logic [7:0]        r_out_mem [TOTAL];

  // Loop counters, innermost kc .. outermost oc.
  logic [KW-1:0]   r_kc, r_kr;
  logic [ICW-1:0]  r_ic;
  logic [OWW-1:0]  r_ocol;
  logic [OHW-1:0]  r_orow;
  logic [BA_W-1:0] r_oc;
  logic            r_mac_done;
  logic [31:0]     r_acc;

  // One-deep stage between the MAC and the output RAM: holds a finished
  // accumulator so the wide requantize multiply gets its own cycle.
  logic              r_fin_vld;
  logic signed [31:0] r_fin_acc;
  logic [OA_W-1:0]   r_fin_idx;
  logic              r_fin_last;

  logic [SW-1:0] r_sidx;
  logic          r_done;
  logic          r_valid;
  logic [7:0]    r_result;

  logic [IA_W-1:0]    w_in_addr;
  logic [WA_W-1:0]    w_w_addr;
  logic [OA_W-1:0]    w_out_idx;
  logic [7:0]         w_act;
  logic signed [7:0]  w_wgt;
  logic signed [16:0] w_prod;
  logic [31:0]        w_acc_nxt;
  logic               w_first, w_last_mac, w_last_pix, w_mac_en;
  logic signed [63:0] w_p, w_q, w_y;
  logic [7:0]         w_qout;

  assign done        = r_done;
  assign conv_valid  = r_valid;
  assign conv_result = r_result;

  // ---------------- MAC datapath ----------------
  assign w_in_addr = IA_W'(int'(r_ic)*H*W + (int'(r_orow) + int'(r_kr))*W
                           + int'(r_ocol) + int'(r_kc));
  assign w_w_addr  = WA_W'(((int'(r_oc)*IC + int'(r_ic))*K + int'(r_kr))*K + int'(r_kc));
  assign w_out_idx = OA_W'(int'(r_oc)*NPIX + int'(r_orow)*OW + int'(r_ocol));

  assign w_act  = r_in_mem[w_in_addr];
  assign w_wgt  = r_w_mem[w_w_addr];
  // Activation zero-extended, weight sign-extended: 9b x 8b fits in 17b signed.
  assign w_prod = $signed({9'd0, w_act}) * $signed({{9{w_wgt[7]}}, w_wgt});

  assign w_first    = (r_ic == '0) && (r_kr == '0) && (r_kc == '0);
  assign w_last_mac = (r_ic == IC_LAST) && (r_kr == K_LAST) && (r_kc == K_LAST);
  assign w_last_pix = (r_oc == OC_LAST) && (r_orow == OH_LAST) && (r_ocol == OW_LAST);
  assign w_mac_en   = (r_state == S_COMPUTE) && !r_mac_done;

  // First tap of a pixel starts from the bias instead of the running sum.
  assign w_acc_nxt = (w_first ? r_b_mem[r_oc] : r_acc) + {{15{w_prod[16]}}, w_prod};

  // ---------------- requantize + ReLU/saturate ----------------
  always_comb begin
    w_p = $signed({{32{r_fin_acc[31]}}, r_fin_acc}) * $signed({32'd0, SCALE});
`ifdef QCONV_ROUND_NEAREST_EN
    w_q = (w_p + 64'sd33554432) >>> 26;
`else
    w_q = w_p >>> 26;
`endif
    w_y    = w_q + $signed({56'd0, ZERO_POINT});
    w_qout = w_y[7:0];
    if (w_y < $signed({56'd0, ZERO_POINT})) w_qout = ZERO_POINT;
    else if (w_y > 64'sd255)                w_qout = 8'hFF;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (r_fin_vld && r_fin_last) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_WAIT;
      S_WAIT:    w_state_nxt = S_STREAM;
      S_STREAM:  if (r_sidx == S_END) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- control / counters / stream ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_kc <= '0; r_kr <= '0; r_ic <= '0;
      r_ocol <= '0; r_orow <= '0; r_oc <= '0;
      r_mac_done <= 1'b0;
      r_acc      <= '0;
      r_fin_vld  <= 1'b0;
      r_fin_acc  <= '0;
      r_fin_idx  <= '0;
      r_fin_last <= 1'b0;
      r_sidx     <= '0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done    <= (w_state_nxt == S_DONE);
      r_fin_vld <= w_mac_en && w_last_mac;

      if (r_state == S_IDLE && start) begin
        r_kc <= '0; r_kr <= '0; r_ic <= '0;
        r_ocol <= '0; r_orow <= '0; r_oc <= '0;
        r_mac_done <= 1'b0;
      end

      if (w_mac_en) begin
        r_acc <= w_acc_nxt;
        if (w_last_mac) begin
          r_fin_acc  <= w_acc_nxt;
          r_fin_idx  <= w_out_idx;
          r_fin_last <= w_last_pix;
          if (w_last_pix) r_mac_done <= 1'b1;
        end
        if (r_kc != K_LAST) r_kc <= r_kc + KW'(1);
        else begin
          r_kc <= '0;
          if (r_kr != K_LAST) r_kr <= r_kr + KW'(1);
          else begin
            r_kr <= '0;
            if (r_ic != IC_LAST) r_ic <= r_ic + ICW'(1);
            else begin
              r_ic <= '0;
              if (r_ocol != OW_LAST) r_ocol <= r_ocol + OWW'(1);
              else begin
                r_ocol <= '0;
                if (r_orow != OH_LAST) r_orow <= r_orow + OHW'(1);
                else begin
                  r_orow <= '0;
                  if (r_oc != OC_LAST) r_oc <= r_oc + BA_W'(1);
                  else                 r_oc <= '0;
                end
              end
            end
          end
        end
      end

      case (r_state)
        S_WAIT: begin
          r_valid  <= 1'b1;
          r_result <= r_out_mem[0];
          r_sidx   <= SW'(1);
        end
        S_STREAM: begin
          if (r_sidx == S_END) begin
            r_valid  <= 1'b0;
            r_result <= '0;
          end else begin
            r_valid  <= 1'b1;
            r_result <= r_out_mem[OA_W'(r_sidx)];
            r_sidx   <= r_sidx + SW'(1);
          end
        end
        default: begin
          r_valid  <= 1'b0;
          r_result <= '0;
        end
      endcase
    end
  end

  // ---------------- RAM writes ----------------
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      if (input_data_we)  r_in_mem[input_data_addr]  <= input_data_in;
      if (weight_data_we) r_w_mem[weight_data_addr]  <= weight_data_in;
      if (bias_data_we)   r_b_mem[bias_data_addr]    <= bias_data_in;
    end
    if (r_fin_vld) r_out_mem[r_fin_idx] <= w_qout;
  end

endmodule

// File: tb/tb_quantized_conv_relu2d.sv
// Directed bench for quantized_conv_relu2d on a reduced geometry
// (IC=2, OC=4, K=3, 6x6 input -> 4x4 output, 64 outputs), SCALE=2^25 (x0.5)
// and ZERO_POINT=10 so that clamping, saturation and rounding are all visible.
module tb_quantized_conv_relu2d;
  localparam int IC = 2, OC = 4, K = 3, H = 6, W = 6;
  localparam int OH = H - K + 1, OW = W - K + 1, NPIX = OH * OW, TOTAL = OC * NPIX;
  localparam int IN_D = IC * H * W, WT_D = OC * IC * K * K;
  localparam int IA = $clog2(IN_D), WA = $clog2(WT_D), BA = $clog2(OC);
  localparam logic [31:0] SC = 32'd33554432;
  localparam logic [7:0]  ZP = 8'd10;
`ifdef QCONV_ROUND_NEAREST_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn, start, done;
  logic [7:0]    input_data_in;
  logic          input_data_we;
  logic [IA-1:0] input_data_addr;
  logic [7:0]    weight_data_in;
  logic          weight_data_we;
  logic [WA-1:0] weight_data_addr;
  logic [31:0]   bias_data_in;
  logic          bias_data_we;
  logic [BA-1:0] bias_data_addr;
  logic [7:0]    conv_result;
  logic          conv_valid;

  always #5 clk = ~clk;

  quantized_conv_relu2d #(
    .INPUT_CHANNELS(IC), .OUTPUT_CHANNELS(OC), .KERNEL_SIZE(K),
    .INPUT_WIDTH(W), .INPUT_HEIGHT(H), .SCALE(SC), .ZERO_POINT(ZP)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .done(done),
    .input_data_in(input_data_in), .input_data_we(input_data_we),
    .input_data_addr(input_data_addr),
    .weight_data_in(weight_data_in), .weight_data_we(weight_data_we),
    .weight_data_addr(weight_data_addr),
    .bias_data_in(bias_data_in), .bias_data_we(bias_data_we),
    .bias_data_addr(bias_data_addr),
    .conv_result(conv_result), .conv_valid(conv_valid)
  );

  int checks = 0, errors = 0;
  int in_buf [IN_D];
  int w_buf  [WT_D];
  int b_buf  [OC];
  int exp_q  [TOTAL];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rq(input longint acc);
    longint p, q, y;
    p = acc * longint'(SC);
    q = RND ? ((p + (longint'(1) <<< 25)) >>> 26) : (p >>> 26);
    y = q + longint'(ZP);
    if (y < longint'(ZP)) return int'(ZP);
    if (y > 255) return 255;
    return int'(y);
  endfunction

  task automatic fill_uniform(input int a, input int wv, input int b0, input int b1,
                              input int b2, input int b3);
    for (int i = 0; i < IN_D; i++) in_buf[i] = a;
    for (int i = 0; i < WT_D; i++) w_buf[i] = wv;
    b_buf[0] = b0; b_buf[1] = b1; b_buf[2] = b2; b_buf[3] = b3;
  endtask

  task automatic exp_per_ch(input int e0, input int e1, input int e2, input int e3);
    int ev[OC];
    ev = '{e0, e1, e2, e3};
    for (int i = 0; i < TOTAL; i++) exp_q[i] = ev[i / NPIX];
  endtask

  task automatic load_all();
    for (int i = 0; i < IN_D; i++) begin
      @(negedge clk);
      input_data_we  = 1'b1; input_data_addr  = IA'(i); input_data_in  = 8'(in_buf[i]);
      weight_data_we = (i < WT_D); weight_data_addr = WA'(i); weight_data_in = 8'(w_buf[i]);
      bias_data_we   = (i < OC); bias_data_addr = BA'(i); bias_data_in = 32'(b_buf[i % OC]);
    end
    @(negedge clk);
    input_data_we = 1'b0; weight_data_we = 1'b0; bias_data_we = 1'b0;
  endtask

  // Start, optionally with a same-cycle bias write; optionally try writes
  // while busy and a start pulse mid-stream (both must be ignored).
  task automatic run(input string tn, input bit wr_on_start, input int wa, input int wv,
                     input bit poke);
    bit got;
    int gaps, extra;
    @(negedge clk);
    start = 1'b1;
    if (wr_on_start) begin
      bias_data_we = 1'b1; bias_data_addr = BA'(wa); bias_data_in = 32'(wv);
    end
    @(negedge clk);
    start = 1'b0; bias_data_we = 1'b0;
    if (poke) begin
      bias_data_we = 1'b1; bias_data_addr = '0; bias_data_in = 32'd1000;
      input_data_we = 1'b1; input_data_addr = '0; input_data_in = 8'd200;
      @(negedge clk);
      bias_data_we = 1'b0; input_data_we = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 5000 && !got; c++) begin
      if (done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    chk({tn, ":done_seen"}, 32'(got), 32'd1);
    if (got) begin
      @(negedge clk);
      chk({tn, ":done_one_cycle"}, 32'(done), 32'd0);
      chk({tn, ":no_valid_wait"}, 32'(conv_valid), 32'd0);
      @(negedge clk);
      gaps = 0;
      for (int i = 0; i < TOTAL; i++) begin
        if (conv_valid !== 1'b1) gaps++;
        chk($sformatf("%s:out%0d", tn, i), 32'(conv_result), 32'(exp_q[i]));
        start = poke && (i == 5);
        @(negedge clk);
      end
      start = 1'b0;
      chk({tn, ":valid_gaps"}, 32'(gaps), 32'd0);
      chk({tn, ":valid_after"}, 32'(conv_valid), 32'd0);
      extra = 0;
      for (int c = 0; c < 20; c++) begin
        if (done !== 1'b0 || conv_valid !== 1'b0) extra++;
        @(negedge clk);
      end
      chk({tn, ":quiet_after"}, 32'(extra), 32'd0);
    end
  endtask

  task automatic model_conv();
    longint acc;
    for (int oc = 0; oc < OC; oc++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++) begin
          acc = b_buf[oc];
          for (int ic = 0; ic < IC; ic++)
            for (int kr = 0; kr < K; kr++)
              for (int kc = 0; kc < K; kc++)
                acc += longint'(in_buf[ic*H*W + (r+kr)*W + c + kc]) *
                       longint'(w_buf[((oc*IC + ic)*K + kr)*K + kc]);
          exp_q[oc*NPIX + r*OW + c] = rq(acc);
        end
  endtask

  initial begin
    int ev;
    rstn = 1'b0; start = 1'b0;
    input_data_we = 1'b0; input_data_addr = '0; input_data_in = '0;
    weight_data_we = 1'b0; weight_data_addr = '0; weight_data_in = '0;
    bias_data_we = 1'b0; bias_data_addr = '0; bias_data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset:done", 32'(done), 32'd0);
    chk("reset:valid", 32'(conv_valid), 32'd0);
    chk("reset:result", 32'(conv_result), 32'd0);
    rstn = 1'b1;

    // acc=18 -> 9 -> +10 = 19; busy writes and mid-stream start ignored
    fill_uniform(1, 1, 0, 0, 0, 0); load_all();
    exp_per_ch(19, 19, 19, 19);
    run("ones", 1'b0, 0, 0, 1'b1);

    // acc=-18 -> below zero point -> 10
    fill_uniform(1, -1, 0, 0, 0, 0); load_all();
    exp_per_ch(10, 10, 10, 10);
    run("neg", 1'b0, 0, 0, 1'b0);

    // acc=582930 -> saturate 255
    fill_uniform(255, 127, 0, 0, 0, 0); load_all();
    exp_per_ch(255, 255, 255, 255);
    run("sat", 1'b0, 0, 0, 1'b0);

    // per-channel bias, last bias written in the start cycle:
    // acc {13,29,9,-22} -> {6.5,14.5,4.5,-11}
    fill_uniform(1, 1, -5, 11, -9, 0); load_all();
    if (RND) exp_per_ch(17, 25, 15, 10); else exp_per_ch(16, 24, 14, 10);
    run("bias", 1'b1, 3, -40, 1'b0);

    // weights 0: acc = bias {3,490,491,-3} -> {1.5,245,245.5,-1.5}
    fill_uniform(1, 0, 3, 490, 491, -3); load_all();
    if (RND) exp_per_ch(12, 255, 255, 10); else exp_per_ch(11, 255, 255, 10);
    run("round", 1'b0, 0, 0, 1'b0);

    // position-dependent data checks window and channel indexing
    for (int c = 0; c < IC; c++)
      for (int r = 0; r < H; r++)
        for (int col = 0; col < W; col++)
          in_buf[c*H*W + r*W + col] = (c*3 + r*2 + col) % 16;
    for (int i = 0; i < WT_D; i++) w_buf[i] = ((i / 9) + (i % 9) * 2) % 5 - 2;
    for (int oc = 0; oc < OC; oc++) b_buf[oc] = oc * 40 - 50;
    load_all();
    model_conv();
    run("pattern", 1'b0, 0, 0, 1'b0);

    // reset mid-compute aborts; retained buffers give the same result again
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort:done", 32'(done), 32'd0);
    chk("abort:valid", 32'(conv_valid), 32'd0);
    rstn = 1'b1;
    ev = 0;
    for (int c = 0; c < 1500; c++) begin
      if (done !== 1'b0 || conv_valid !== 1'b0) ev++;
      @(negedge clk);
    end
    chk("abort:quiet", 32'(ev), 32'd0);
    run("rerun", 1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
